// File: rtl/bram_mem_port.sv
// Block-RAM responder for the LPDDR controller user port 0.
// Command, write-data and read-data FIFOs behave like the controller's
// port-0 FIFOs. A small engine drains commands into a word-addressed RAM.
module bram_mem_port #(
  parameter int ADDR_WIDTH   = 12,
  parameter int CMD_DEPTH    = 4,
  parameter int DATA_DEPTH   = 64,
  parameter int CALIB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_byte_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error,
  output logic        calib_done
);

  localparam int CPW  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CCW  = $clog2(CMD_DEPTH + 1);
  localparam int DPW  = $clog2(DATA_DEPTH);
  localparam int CALW = $clog2(CALIB_CYCLES + 1);

  localparam logic [CCW-1:0]  CMD_FULL_CNT  = CCW'(CMD_DEPTH);
  localparam logic [6:0]      DATA_FULL_CNT = 7'(DATA_DEPTH);
  localparam logic [CALW-1:0] CAL_LAST      = CALW'(CALIB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t state_q, state_d;

  // ---------------- calibration timer ----------------
  logic [CALW-1:0] cal_cnt_q;
  logic            calib_q;

  // Count clocks from reset release; calib_done then holds until next reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cal_cnt_q <= '0;
      calib_q   <= 1'b0;
    end else if (!calib_q) begin
      cal_cnt_q <= cal_cnt_q + 1'b1;
      if (cal_cnt_q == CAL_LAST) calib_q <= 1'b1;
    end
  end

  assign calib_done = calib_q;

  // ---------------- command FIFO ----------------
  logic [2:0]            cmd_instr_mem [CMD_DEPTH];
  logic [5:0]            cmd_bl_mem    [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] cmd_addr_mem  [CMD_DEPTH];
  logic [CPW-1:0]        cmd_wp_q, cmd_rp_q;
  logic [CCW-1:0]        cmd_cnt_q;
  logic                  cmd_push, cmd_pop;

  assign cmd_empty = (cmd_cnt_q == '0);
  assign cmd_full  = (cmd_cnt_q == CMD_FULL_CNT);
  assign cmd_push  = cmd_en && !cmd_full;

  // Command storage; only the word-address bits are kept.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_instr_mem[cmd_wp_q] <= cmd_instr;
      cmd_bl_mem[cmd_wp_q]    <= cmd_bl;
      cmd_addr_mem[cmd_wp_q]  <= cmd_byte_addr[ADDR_WIDTH+1:2];
    end
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      cmd_cnt_q <= '0;
    end else begin
      if (cmd_push) cmd_wp_q <= cmd_wp_q + 1'b1;
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt_q <= cmd_cnt_q + 1'b1;
        2'b01:   cmd_cnt_q <= cmd_cnt_q - 1'b1;
        default: cmd_cnt_q <= cmd_cnt_q;
      endcase
    end
  end

  // ---------------- write-data FIFO ----------------
  logic [35:0]    wr_mem [DATA_DEPTH];
  logic [DPW-1:0] wr_wp_q, wr_rp_q;
  logic [6:0]     wr_cnt_q;
  logic           wr_push, wr_pop;
  logic [35:0]    wr_head;

  assign wr_empty = (wr_cnt_q == '0);
  assign wr_full  = (wr_cnt_q == DATA_FULL_CNT);
  assign wr_count = wr_cnt_q;
  assign wr_push  = wr_en && !wr_full;
  assign wr_head  = wr_mem[wr_rp_q];

  // Write-data storage: {mask, data}.
  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wr_wp_q] <= {wr_mask, wr_data};
  end

  // Write FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_wp_q  <= '0;
      wr_rp_q  <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (wr_push) wr_wp_q <= wr_wp_q + 1'b1;
      if (wr_pop)  wr_rp_q <= wr_rp_q + 1'b1;
      case ({wr_push, wr_pop})
        2'b10:   wr_cnt_q <= wr_cnt_q + 1'b1;
        2'b01:   wr_cnt_q <= wr_cnt_q - 1'b1;
        default: wr_cnt_q <= wr_cnt_q;
      endcase
    end
  end

  // ---------------- read-data FIFO ----------------
  logic [31:0]    rd_mem [DATA_DEPTH];
  logic [DPW-1:0] rd_wp_q, rd_rp_q;
  logic [6:0]     rd_cnt_q;
  logic           rd_push, rd_pop;
  logic           rd_valid_q;
  logic [31:0]    ram_rd_q;

  assign rd_empty    = (rd_cnt_q == '0);
  assign rd_full     = (rd_cnt_q == DATA_FULL_CNT);
  assign rd_count    = rd_cnt_q;
  assign rd_push     = rd_valid_q && !rd_full;
  assign rd_pop      = rd_en && !rd_empty;
  assign rd_overflow = rd_valid_q && rd_full;
  assign rd_data     = rd_empty ? 32'h0 : rd_mem[rd_rp_q];

  // Read-data storage, filled from the registered RAM output.
  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wp_q] <= ram_rd_q;
  end

  // Read FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_wp_q  <= '0;
      rd_rp_q  <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (rd_push) rd_wp_q <= rd_wp_q + 1'b1;
      if (rd_pop)  rd_rp_q <= rd_rp_q + 1'b1;
      case ({rd_push, rd_pop})
        2'b10:   rd_cnt_q <= rd_cnt_q + 1'b1;
        2'b01:   rd_cnt_q <= rd_cnt_q - 1'b1;
        default: rd_cnt_q <= rd_cnt_q;
      endcase
    end
  end

  // ---------------- sticky error flags ----------------
  logic wr_error_q, rd_error_q;

  // Errors accumulate until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      wr_error_q <= wr_error_q | (wr_en & wr_full) | wr_underrun;
      rd_error_q <= rd_error_q | rd_overflow | (rd_en & rd_empty);
    end
  end

  assign wr_error = wr_error_q;
  assign rd_error = rd_error_q;

  // ---------------- engine ----------------
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [5:0]            beats_q;
  logic                  ram_we, ram_re;
  logic [2:0]            head_instr;

  assign head_instr = cmd_instr_mem[cmd_rp_q];

  // Engine state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Engine next-state: a burst ends on the beat where beats_q reaches zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (calib_q && !cmd_empty) begin
          case (head_instr)
            3'b000, 3'b010: state_d = S_WRITE;
            3'b001, 3'b011: state_d = S_READ;
            default:        state_d = S_IDLE;
          endcase
        end
      end
      S_WRITE: if (!wr_empty && beats_q == 6'd0) state_d = S_IDLE;
      S_READ:  if (beats_q == 6'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Engine outputs: FIFO pops, RAM strobes and the underrun indication.
  always_comb begin
    cmd_pop     = 1'b0;
    wr_pop      = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    wr_underrun = 1'b0;
    case (state_q)
      S_IDLE:  cmd_pop = calib_q && !cmd_empty;
      S_WRITE: begin
        if (!wr_empty) begin
          wr_pop = 1'b1;
          ram_we = 1'b1;
        end else begin
          wr_underrun = 1'b1;
        end
      end
      S_READ:  ram_re = 1'b1;
      default: ;
    endcase
  end

  // Burst address and remaining-beat counter; address wraps at the RAM size.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else if (cmd_pop) begin
      addr_q  <= cmd_addr_mem[cmd_rp_q];
      beats_q <= cmd_bl_mem[cmd_rp_q];
    end else if (ram_we || ram_re) begin
      addr_q  <= addr_q + 1'b1;
      beats_q <= beats_q - 1'b1;
    end
  end

  // ---------------- backing RAM ----------------
  logic [31:0] ram [2**ADDR_WIDTH];

  // Byte-masked write port and registered read port; contents never reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head[32+b]) ram[addr_q][8*b +: 8] <= wr_head[8*b +: 8];
      end
    end
    if (ram_re) ram_rd_q <= ram[addr_q];
  end

  // A read issued this cycle lands in the read FIFO next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_valid_q <= 1'b0;
    else        rd_valid_q <= ram_re;
  end

endmodule

// File: tb/tb_bram_mem_port.sv
// Directed testbench for bram_mem_port.
module tb_bram_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_empty, cmd_full;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full, wr_empty, wr_underrun, wr_error;
  logic [6:0]  wr_count;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full, rd_empty, rd_overflow, rd_error;
  logic [6:0]  rd_count;
  logic        calib_done;

  int checks = 0;
  int errors = 0;
  int ov_cnt;

  always #5 clk = ~clk;

  bram_mem_port dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
    .wr_underrun(wr_underrun), .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error),
    .calib_done(calib_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [2:0] i, input logic [5:0] bl, input logic [29:0] a);
    cmd_en = 1'b1; cmd_instr = i; cmd_bl = bl; cmd_byte_addr = a;
    tick();
    cmd_en = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; wr_data = d; wr_mask = m;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, ".cmd_empty"},   32'(cmd_empty),   32'd1);
    chk({p, ".cmd_full"},    32'(cmd_full),    32'd0);
    chk({p, ".wr_empty"},    32'(wr_empty),    32'd1);
    chk({p, ".wr_full"},     32'(wr_full),     32'd0);
    chk({p, ".wr_count"},    32'(wr_count),    32'd0);
    chk({p, ".wr_underrun"}, 32'(wr_underrun), 32'd0);
    chk({p, ".wr_error"},    32'(wr_error),    32'd0);
    chk({p, ".rd_empty"},    32'(rd_empty),    32'd1);
    chk({p, ".rd_full"},     32'(rd_full),     32'd0);
    chk({p, ".rd_count"},    32'(rd_count),    32'd0);
    chk({p, ".rd_overflow"}, 32'(rd_overflow), 32'd0);
    chk({p, ".rd_error"},    32'(rd_error),    32'd0);
    chk({p, ".calib_done"},  32'(calib_done),  32'd0);
    chk({p, ".rd_data"},     rd_data,          32'h0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_byte_addr = '0;
    wr_en = 1'b0; wr_mask = '0; wr_data = '0; rd_en = 1'b0;
    @(negedge clk);
    tick(); tick(); tick();
    check_reset_vals("rst0");

    // 1: calibration timing, command held until calib_done
    rst_n = 1'b1;
    tick();                                     // edge 1
    chk("cal.e1", 32'(calib_done), 32'd0);
    cmd_en = 1'b1; cmd_instr = 3'b100; cmd_bl = '0; cmd_byte_addr = '0;
    tick();                                     // edge 2
    cmd_en = 1'b0;
    chk("cal.cmd_held_e2", 32'(cmd_empty), 32'd0);
    for (int k = 3; k <= 15; k++) begin
      tick();
      chk($sformatf("cal.e%0d", k), 32'(calib_done), 32'd0);
    end
    chk("cal.cmd_held_e15", 32'(cmd_empty), 32'd0);
    tick();                                     // edge 16
    chk("cal.e16", 32'(calib_done), 32'd1);
    chk("cal.cmd_held_e16", 32'(cmd_empty), 32'd0);
    tick();                                     // edge 17: refresh popped
    chk("cal.cmd_popped", 32'(cmd_empty), 32'd1);
    chk("cal.rd_empty", 32'(rd_empty), 32'd1);

    // 2: four-beat write then read, read latency
    push_wr(32'h11111111, 4'h0);
    push_wr(32'h22222222, 4'h0);
    push_wr(32'h33333333, 4'h0);
    push_wr(32'h44444444, 4'h0);
    chk("t2.wr_count", 32'(wr_count), 32'd4);
    push_cmd(3'b000, 6'd3, 30'h100);
    repeat (5) tick();
    chk("t2.wr_empty", 32'(wr_empty), 32'd1);
    push_cmd(3'b001, 6'd3, 30'h100);            // E
    chk("t2.rd_empty_E", 32'(rd_empty), 32'd1);
    tick(); tick();                             // E+2
    chk("t2.rd_empty_E2", 32'(rd_empty), 32'd1);
    tick();                                     // E+3
    chk("t2.rd_empty_E3", 32'(rd_empty), 32'd0);
    repeat (3) tick();
    chk("t2.rd_count", 32'(rd_count), 32'd4);
    chk("t2.d0", rd_data, 32'h11111111); pop_rd();
    chk("t2.d1", rd_data, 32'h22222222); pop_rd();
    chk("t2.d2", rd_data, 32'h33333333); pop_rd();
    chk("t2.d3", rd_data, 32'h44444444); pop_rd();
    chk("t2.rd_empty_end", 32'(rd_empty), 32'd1);

    // 3: byte mask merge
    push_wr(32'hAABBCCDD, 4'b0000);
    push_cmd(3'b000, 6'd0, 30'h40);
    repeat (3) tick();
    push_wr(32'h11223344, 4'b0101);
    push_cmd(3'b010, 6'd0, 30'h40);
    repeat (3) tick();
    push_cmd(3'b011, 6'd0, 30'h40);
    repeat (3) tick();
    chk("t3.merge", rd_data, 32'h11BB33DD);
    chk("t3.wr_error", 32'(wr_error), 32'd0);
    pop_rd();

    // 4: write underrun
    push_wr(32'hCAFEF00D, 4'h0);
    push_cmd(3'b000, 6'd1, 30'h200);            // E
    tick();                                     // E+1 pop
    chk("t4.no_underrun_E1", 32'(wr_underrun), 32'd0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk($sformatf("t4.underrun_E%0d", k), 32'(wr_underrun), 32'd1);
    end
    chk("t4.wr_error", 32'(wr_error), 32'd1);
    push_wr(32'hBEEF0001, 4'h0);                // E+7
    chk("t4.underrun_cleared", 32'(wr_underrun), 32'd0);
    tick();                                     // E+8 second beat written
    chk("t4.wr_empty", 32'(wr_empty), 32'd1);
    chk("t4.idle_no_underrun", 32'(wr_underrun), 32'd0);
    push_cmd(3'b001, 6'd1, 30'h200);
    repeat (4) tick();
    chk("t4.rd_count", 32'(rd_count), 32'd2);
    chk("t4.d0", rd_data, 32'hCAFEF00D); pop_rd();
    chk("t4.d1", rd_data, 32'hBEEF0001); pop_rd();

    // 5: read FIFO overflow
    push_wr(32'h5A5A0000, 4'h0);
    push_cmd(3'b000, 6'd0, 30'h0);
    repeat (3) tick();
    push_cmd(3'b001, 6'd63, 30'h0);
    push_cmd(3'b001, 6'd63, 30'h0);
    ov_cnt = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (rd_overflow) ov_cnt++;
    end
    chk("t5.ov_pulses", 32'(ov_cnt), 32'd64);
    chk("t5.rd_full", 32'(rd_full), 32'd1);
    chk("t5.rd_count", 32'(rd_count), 32'd64);
    chk("t5.rd_error", 32'(rd_error), 32'd1);
    chk("t5.rd_data", rd_data, 32'h5A5A0000);
    rd_en = 1'b1;
    repeat (64) tick();
    rd_en = 1'b0;
    chk("t5.drained", 32'(rd_empty), 32'd1);

    // 6: address wrap, ignored byte-address bits, reset mid-burst
    push_wr(32'hA0A0A0A0, 4'h0);
    push_wr(32'hB0B0B0B0, 4'h0);
    push_cmd(3'b000, 6'd1, 30'h0100_3FFE);
    repeat (4) tick();
    push_cmd(3'b001, 6'd0, 30'h0);
    repeat (3) tick();
    chk("t6.wrap_B", rd_data, 32'hB0B0B0B0);
    pop_rd();
    push_cmd(3'b001, 6'd0, 30'h3FFC);
    repeat (3) tick();
    chk("t6.last_A", rd_data, 32'hA0A0A0A0);
    pop_rd();
    push_cmd(3'b001, 6'd63, 30'h0);
    repeat (5) tick();
    chk("t6.burst_running", 32'(rd_empty), 32'd0);
    rst_n = 1'b0;
    tick();
    check_reset_vals("rst1");
    tick();
    chk("rst1.no_late_push", 32'(rd_count), 32'd0);
    rst_n = 1'b1;

    // Command FIFO full before calibration, pop-while-empty, write push-while-full
    for (int k = 0; k < 4; k++) push_cmd(3'b100, 6'd0, 30'h0);
    chk("cf.cmd_full", 32'(cmd_full), 32'd1);
    push_cmd(3'b100, 6'd0, 30'h0);
    chk("cf.cmd_still_full", 32'(cmd_full), 32'd1);
    pop_rd();
    chk("cf.rd_error", 32'(rd_error), 32'd1);
    chk("cf.rd_count", 32'(rd_count), 32'd0);
    chk("cf.wr_error_pre", 32'(wr_error), 32'd0);
    for (int k = 0; k < 64; k++) push_wr(32'(k), 4'h0);
    chk("cf.wr_full", 32'(wr_full), 32'd1);
    chk("cf.wr_error_at_full", 32'(wr_error), 32'd0);
    push_wr(32'hDEAD0000, 4'h0);
    chk("cf.wr_count", 32'(wr_count), 32'd64);
    chk("cf.wr_error", 32'(wr_error), 32'd1);
    repeat (20) tick();
    chk("cf.cmd_drained", 32'(cmd_empty), 32'd1);
    chk("cf.calib_done", 32'(calib_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
